// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end of the command RAM.
package spi_pkg;

  localparam int ADDR_SIZE_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: loads a parallel byte and drives it MSB first, one bit per
// clock; done flags the last cycle of the final bit.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH = ADDR_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             serial,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // cnt counts the bits still to follow the one currently on serial.
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      serial <= 1'b0;
    end else if (load) begin
      serial <= data[WIDTH-1];
      shreg  <= data << 1;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        serial <= 1'b0;
        busy   <= 1'b0;
      end else begin
        serial <= shreg[WIDTH-1];
        shreg  <= shreg << 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer for the command RAM: assembles MOSI frames, strobes them
// to the RAM and returns read data on MISO. Option macro: SPI_FRAME_ERR_EN.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  spi_state_e         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shift;
  logic               rd_addr_seen;
  logic               tx_wait;
  logic               tx_load;
  logic               tx_busy;
  logic               tx_done;
  logic               receiving;
  logic               frame_last;

  assign receiving  = (bit_cnt != CNT_W'(FRAME_W));
  assign frame_last = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign tx_load    = (state == READ_DATA) && !ss_n && tx_wait && tx_valid && !tx_busy;

  // NOTE: every register here is updated with <= so all branches see the
  // values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_wait      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (tx_done) rd_addr_seen <= 1'b0;

      if (ss_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shift   <= '0;
        tx_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;

          CHK_CMD: begin
            shift   <= {shift[FRAME_W-3:0], mosi};
            bit_cnt <= CNT_W'(1);
            if (!mosi)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (receiving) begin
              shift   <= {shift[FRAME_W-3:0], mosi};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (frame_last) begin
                rx_data  <= {shift, mosi};
                rx_valid <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
              end
            end
            // Read data is accepted from the cycle after the strobe onward.
            if (state == READ_DATA) begin
              if (rx_valid)     tx_wait <= 1'b1;
              else if (tx_load) tx_wait <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .WIDTH(ADDR_SIZE)
  ) u_tx_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ss_n),
    .load  (tx_load),
    .data  (tx_data),
    .serial(miso),
    .busy  (tx_busy),
    .done  (tx_done)
  );

`ifdef SPI_FRAME_ERR_EN
  // A partial frame or a read-data byte cut off before its last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= ss_n && ((bit_cnt != '0 && receiving) || (tx_busy && !tx_done));
  end
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomized self-checking bench for spi_slave_ctrl against a frame-level model.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  localparam int AW = ADDR_SIZE_DEF;
  localparam int FW = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n, ss_n, mosi, tx_valid;
  logic [AW-1:0] tx_data;
  logic          miso, rx_valid;
  logic [FW-1:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err;
  int            err_pulses = 0;
`endif

  int            n_checks = 0;
  int            n_fail = 0;
  int            err_exp = 0;
  bit            model_seen = 1'b0;
  logic [FW-1:0] last_word = '0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.ADDR_SIZE(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

`ifdef SPI_FRAME_ERR_EN
  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // nbits < FW aborts the frame; for read-data frames ser_bits < AW aborts
  // the MISO byte, and use_reset replaces that abort by a reset.
  task automatic send_frame(input logic [FW-1:0] w, input int nbits, input int tx_gap,
                            input int ser_bits, input bit use_reset);
    bit            is_rd_data;
    logic [AW-1:0] d;
    is_rd_data = w[FW-1] && model_seen;
    ss_n = 1'b0;
    tick;
    for (int i = 0; i < nbits; i++) begin
      check("rx_valid_mid_frame", rx_valid, 0);
      check("miso_rx_phase", miso, 0);
      mosi = w[FW-1-i];
      tick;
    end
    mosi = 1'($urandom);

    if (nbits < FW) begin
      ss_n = 1'b1;
      tick;
      if (nbits > 0) err_exp++;
      check("abort_no_strobe", rx_valid, 0);
      check("abort_rx_data_held", rx_data, last_word);
      tick;
      check("abort_no_strobe_late", rx_valid, 0);
      check("abort_miso", miso, 0);
`ifdef SPI_FRAME_ERR_EN
      check("frame_err_count", err_pulses, err_exp);
`endif
      return;
    end

    check("rx_valid_strobe", rx_valid, 1);
    check("rx_data", rx_data, w);
    last_word = w;
    if (w[FW-1] && !model_seen) model_seen = 1'b1;

    if (!is_rd_data) begin
      repeat ($urandom_range(1, 3)) begin
        mosi = 1'($urandom);
        tick;
        check("single_strobe", rx_valid, 0);
        check("miso_idle", miso, 0);
      end
      ss_n = 1'b1;
      tick;
      return;
    end

    // Cycle R: data offered now must be ignored.
    d        = AW'($urandom);
    tx_data  = ~d;
    tx_valid = 1'b1;
    tick;
    check("single_strobe_rd", rx_valid, 0);
    tx_valid = 1'b0;
    tx_data  = AW'($urandom);
    repeat (tx_gap) begin
      check("miso_wait_tx", miso, 0);
      tick;
    end
    tx_valid = 1'b1;
    tx_data  = d;
    check("miso_before_load", miso, 0);
    tick;
    tx_valid = 1'b0;
    tx_data  = AW'($urandom);
    for (int b = 0; b < ser_bits; b++) begin
      check("miso_bit", miso, d[AW-1-b]);
      tick;
    end

    if (ser_bits == AW) begin
      check("miso_after_bit0", miso, 0);
      model_seen = 1'b0;
      tick;
      check("miso_trailing", miso, 0);
      ss_n = 1'b1;
      tick;
    end else if (use_reset) begin
      rst_n = 1'b0;
      ss_n  = 1'b1;
      tick;
      check("rst_miso", miso, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      rst_n      = 1'b1;
      model_seen = 1'b0;
      last_word  = '0;
      tick;
    end else begin
      ss_n = 1'b1;
      tick;
      err_exp++;
      check("abort_tx_miso", miso, 0);
      tick;
`ifdef SPI_FRAME_ERR_EN
      check("frame_err_count", err_pulses, err_exp);
`endif
    end
  endtask

  initial begin
    logic [FW-1:0] w;
    int            nb;
    int            sb;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) tick;
    check("reset_miso", miso, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    rst_n = 1'b1;
    tick;

    send_frame({CMD_WR_ADDR, 8'h05}, FW, 0, AW, 1'b0);
    send_frame({CMD_WR_DATA, 8'hAA}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_ADDR, 8'h05}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_DATA, 8'h00}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_ADDR, 8'h33}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_DATA, 8'h00}, FW, 2, AW, 1'b0);
    send_frame({CMD_WR_ADDR, 8'hF0}, 4, 0, AW, 1'b0);
    send_frame({CMD_WR_ADDR, 8'hFF}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_ADDR, 8'h10}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_DATA, 8'h00}, FW, 1, 3, 1'b0);
    send_frame({CMD_RD_DATA, 8'h00}, FW, 0, 4, 1'b1);
    send_frame({CMD_RD_ADDR, 8'h22}, FW, 0, AW, 1'b0);
    send_frame({CMD_RD_DATA, 8'h00}, FW, 0, AW, 1'b0);

    for (int n = 0; n < 60; n++) begin
      w  = FW'($urandom);
      nb = ($urandom_range(0, 9) < 8) ? FW : $urandom_range(0, FW - 1);
      sb = ($urandom_range(0, 9) < 8) ? AW : $urandom_range(0, AW - 2);
      send_frame(w, nb, $urandom_range(0, 3), sb, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) tick;
    end

    repeat (3) tick;
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_total", err_pulses, err_exp);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
